sm4_round_key_store: RTL and testbench

Sequential SM4 key-schedule engine and round-key buffer. It accepts a 128-bit master key and computes one round key per cycle, 32 in total. It holds all 32 round keys and serves them to the SM4 cipher datapath by round index, in forward order for encryption or reverse order for decryption. It sits between the key CSR/sideload logic and the round datapath, so the round datapath needs no key logic of its own.

---
 rtl/sm4_pkg.sv | 43 ++++
 rtl/sm4_key_round.sv | 21 ++
 rtl/sm4_round_key_store.sv | 129 ++++++++++++
 tb/tb_sm4_round_key_store.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sm4_pkg.sv
// Shared SM4 key-schedule definitions: family keys, FSM states, S-box and CK generator.
package sm4_pkg;

  localparam int unsigned KEY_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 5;

  localparam logic [WORD_W-1:0] FK0 = 32'ha3b1bac6;
  localparam logic [WORD_W-1:0] FK1 = 32'h56aa3350;
  localparam logic [WORD_W-1:0] FK2 = 32'h677d9197;
  localparam logic [WORD_W-1:0] FK3 = 32'hb27022dc;

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_e;

  // Byte 0 of the S-box sits in the most significant byte of the table.
  localparam logic [2047:0] SBOX_TABLE = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{~x, 3'b000} +: 8];
  endfunction

  // CK byte j of round i is ((4i+j)*7) mod 256, MSB first.
  function automatic logic [WORD_W-1:0] ck_gen(input logic [IDX_W-1:0] round);
    logic [WORD_W-1:0] ck;
    logic [7:0]        idx;
    ck = '0;
    for (int j = 0; j < 4; j++) begin
      idx = {1'b0, round, 2'(j)};
      ck[31-8*j -: 8] = idx * 8'd7;
    end
    return ck;
  endfunction

endpackage

// File: rtl/sm4_key_round.sv
// One combinational SM4 key-schedule step: produces rk_i and the shifted K window.
module sm4_key_round
  import sm4_pkg::*;
(
  input  logic [KEY_W-1:0]  i_state,
  input  logic [WORD_W-1:0] i_ck,
  output logic [KEY_W-1:0]  o_next_state_c,
  output logic [WORD_W-1:0] o_rk_c
);

  logic [WORD_W-1:0] w_x;
  logic [WORD_W-1:0] w_b;

  assign w_x = i_state[95:64] ^ i_state[63:32] ^ i_state[31:0] ^ i_ck;
  assign w_b = {sbox(w_x[31:24]), sbox(w_x[23:16]), sbox(w_x[15:8]), sbox(w_x[7:0])};

  // L'(B) = B ^ (B <<< 13) ^ (B <<< 23)
  assign o_rk_c         = i_state[127:96] ^ w_b ^ {w_b[18:0], w_b[31:19]} ^ {w_b[8:0], w_b[31:9]};
  assign o_next_state_c = {i_state[95:0], o_rk_c};

endmodule

// File: rtl/sm4_round_key_store.sv
// SM4 key-schedule engine: expands one round key per cycle into a 32-entry buffer
// and serves them by round index in encrypt or decrypt order.
module sm4_round_key_store
  import sm4_pkg::*;
#(
  parameter bit RK_OUT_REG = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [KEY_W-1:0]  key_i,
  input  logic              key_valid_i,
  output logic              key_ready_o,
  input  logic              clear_i,
  output logic              busy_o,
  output logic              keys_valid_o,
  input  logic              rk_req_i,
  input  logic              rk_dec_i,
  input  logic [IDX_W-1:0]  rk_idx_i,
  output logic [WORD_W-1:0] rk_o,
  output logic              rk_valid_o
);

  state_e             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_cnt, w_cnt_nxt;
  logic [KEY_W-1:0]   r_kst, w_kst_nxt, w_kst_rnd;
  logic [WORD_W-1:0]  w_rk;
  logic               w_we;
  logic [WORD_W-1:0]  r_mem [32];
  logic               r_key_ready, r_busy, r_keys_valid;
  logic [IDX_W-1:0]   w_addr;
  logic               w_rd_valid;
  logic [WORD_W-1:0]  w_rd_data;

  sm4_key_round u_round (
    .i_state        (r_kst),
    .i_ck           (ck_gen(r_cnt)),
    .o_next_state_c (w_kst_rnd),
    .o_rk_c         (w_rk)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_kst        <= '0;
      r_key_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_keys_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_kst        <= w_kst_nxt;
      r_key_ready  <= (w_state_nxt != EXPAND);
      r_busy       <= (w_state_nxt == EXPAND);
      r_keys_valid <= (w_state_nxt == READY);
    end
  end

  // clear_i overrides everything, including a simultaneous key offer.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_kst_nxt   = r_kst;
    w_we        = 1'b0;
    if (clear_i) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_kst_nxt   = '0;
    end else begin
      case (r_state)
        IDLE, READY: begin
          if (key_valid_i) begin
            w_state_nxt = EXPAND;
            w_cnt_nxt   = '0;
            w_kst_nxt   = key_i ^ {FK0, FK1, FK2, FK3};
          end
        end
        EXPAND: begin
          w_we      = 1'b1;
          w_kst_nxt = w_kst_rnd;
          w_cnt_nxt = r_cnt + 5'd1;
          if (r_cnt == 5'd31) w_state_nxt = READY;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      r_mem[r_cnt] <= w_rk;
    end
  end

  assign key_ready_o  = r_key_ready;
  assign busy_o       = r_busy;
  assign keys_valid_o = r_keys_valid;

  // 31 - idx is the bitwise complement for a 5-bit index.
  assign w_addr     = rk_dec_i ? ~rk_idx_i : rk_idx_i;
  assign w_rd_valid = rk_req_i && r_keys_valid;
  assign w_rd_data  = w_rd_valid ? r_mem[w_addr] : '0;

  generate
    if (RK_OUT_REG) begin : g_rd_reg
      logic [WORD_W-1:0] r_rk;
      logic              r_rk_valid;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_rk       <= '0;
          r_rk_valid <= 1'b0;
        end else begin
          r_rk       <= w_rd_data;
          r_rk_valid <= w_rd_valid;
        end
      end
      assign rk_o       = r_rk;
      assign rk_valid_o = r_rk_valid;
    end else begin : g_rd_comb
      assign rk_o       = w_rd_data;
      assign rk_valid_o = w_rd_valid;
    end
  endgenerate

endmodule

// File: tb/tb_sm4_round_key_store.sv
// Self-checking bench: software SM4 key-schedule model plus a per-cycle output comparator.
module tb_sm4_round_key_store;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key;
  logic         key_valid, key_ready, clear, busy, keys_valid;
  logic         rk_req, rk_dec, rk_valid;
  logic [4:0]   rk_idx;
  logic [31:0]  rk;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [127:0] STD_KEY  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] ZERO_KEY = 128'h0;
  localparam logic [127:0] ALT_KEY  = 128'hdeadbeef00112233445566778899aabb;

  sm4_round_key_store #(.RK_OUT_REG(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .key_i(key), .key_valid_i(key_valid), .key_ready_o(key_ready),
    .clear_i(clear), .busy_o(busy), .keys_valid_o(keys_valid), .rk_req_i(rk_req),
    .rk_dec_i(rk_dec), .rk_idx_i(rk_idx), .rk_o(rk), .rk_valid_o(rk_valid)
  );

  always #5 clk = ~clk;

  logic [2047:0] tb_sbox = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- software model ----------------
  logic [31:0] m_keys [32];
  int          m_phase = 0;      // cycles of expansion still to go
  bit          m_have  = 1'b0;   // a key schedule has been loaded since last clear/reset
  bit          m_rv    = 1'b0;
  logic [31:0] m_rk    = 32'h0;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] t_prime(input logic [31:0] x);
    logic [31:0] b;
    int          v;
    for (int k = 0; k < 4; k++) begin
      v = int'(x[31-8*k -: 8]);
      b[31-8*k -: 8] = tb_sbox[2047-8*v -: 8];
    end
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

  task automatic m_expand(input logic [127:0] mk);
    logic [31:0] k [36];
    logic [31:0] ck;
    k[0] = mk[127:96] ^ 32'ha3b1bac6;
    k[1] = mk[95:64]  ^ 32'h56aa3350;
    k[2] = mk[63:32]  ^ 32'h677d9197;
    k[3] = mk[31:0]   ^ 32'hb27022dc;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
      k[i+4]    = k[i] ^ t_prime(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      m_keys[i] = k[i+4];
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_have  = 1'b0;
      m_rv    = 1'b0;
      m_rk    = 32'h0;
    end else begin
      m_rv = rk_req && m_have && (m_phase == 0);
      m_rk = m_rv ? m_keys[rk_dec ? 31 - int'(rk_idx) : int'(rk_idx)] : 32'h0;
      if (clear) begin
        m_phase = 0;
        m_have  = 1'b0;
      end else if (m_phase != 0) begin
        m_phase--;
      end else if (key_valid) begin
        m_expand(key);
        m_phase = 32;
        m_have  = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("key_ready", 32'(key_ready), 32'(m_phase == 0));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("keys_valid", 32'(keys_valid), 32'(m_have && m_phase == 0));
    check("rk_valid", 32'(rk_valid), 32'(m_rv));
    check("rk", rk, m_rk);
  end

  // ---------------- directed stimulus ----------------
  task automatic rd(input bit d, input int i, output logic [31:0] v, output logic vv);
    rk_req = 1'b1; rk_dec = d; rk_idx = 5'(i);
    @(negedge clk);
    v = rk; vv = rk_valid;
    rk_req = 1'b0;
  endtask

  // Offer a key from a negedge and count cycles until keys_valid_o (bounded).
  task automatic load_and_wait(input logic [127:0] k, input bit poke, output int cyc);
    key = k; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; cyc = 1;
    while (!keys_valid && cyc < 40) begin
      if (poke && cyc == 3) begin
        check("ready_in_expand", 32'(key_ready), 32'h0);
        key = ALT_KEY; key_valid = 1'b1; rk_req = 1'b1; rk_idx = 5'd0; rk_dec = 1'b0;
        @(negedge clk);
        check("rd_in_expand_v", 32'(rk_valid), 32'h0);
        check("rd_in_expand_d", rk, 32'h0);
        key_valid = 1'b0; rk_req = 1'b0;
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
  endtask

  logic [31:0] v;
  logic        vv;
  int          cyc, pulses;

  initial begin
    rst = 1'b1; clear = 1'b0; key = '0; key_valid = 1'b0;
    rk_req = 1'b0; rk_dec = 1'b0; rk_idx = '0;
    @(negedge clk);
    check("rst_key_ready", 32'(key_ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_keys_valid", 32'(keys_valid), 32'h0);
    check("rst_rk_valid", 32'(rk_valid), 32'h0);
    check("rst_rk", rk, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    rd(1'b0, 0, v, vv);
    check("rd_after_rst_v", 32'(vv), 32'h0);
    check("rd_after_rst_d", v, 32'h0);

    load_and_wait(STD_KEY, 1'b1, cyc);
    check("std_latency", 32'(cyc), 32'd33);
    check("model_rk0", m_keys[0], 32'hf12186f9);
    check("model_rk1", m_keys[1], 32'h41662b61);
    check("model_rk31", m_keys[31], 32'h9124a012);
    rd(1'b0, 0, v, vv);  check("enc_idx0", v, 32'hf12186f9);  check("enc_idx0_v", 32'(vv), 32'h1);
    rd(1'b0, 1, v, vv);  check("enc_idx1", v, 32'h41662b61);
    rd(1'b0, 31, v, vv); check("enc_idx31", v, 32'h9124a012);
    rd(1'b1, 0, v, vv);  check("dec_idx0", v, 32'h9124a012);
    rd(1'b1, 31, v, vv); check("dec_idx31", v, 32'hf12186f9);

    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      rk_req = 1'b1; rk_dec = 1'b1; rk_idx = 5'(i);
      @(negedge clk);
      if (rk_valid) pulses++;
    end
    rk_req = 1'b0;
    check("sweep_pulses", 32'(pulses), 32'd32);

    // rekey with all-zero key while READY
    key = ZERO_KEY; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("rekey_kv_falls", 32'(keys_valid), 32'h0);
    cyc = 1;
    while (!keys_valid && cyc < 40) begin @(negedge clk); cyc++; end
    check("rekey_latency", 32'(cyc), 32'd33);
    rd(1'b0, 0, v, vv);
    check("zero_key_rk0", v, m_keys[0]);

    // clear with simultaneous offer at cycle 10 of expansion
    key = STD_KEY; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (9) @(negedge clk);
    clear = 1'b1; key = ALT_KEY; key_valid = 1'b1;
    @(negedge clk);
    clear = 1'b0; key_valid = 1'b0;
    check("clr_busy", 32'(busy), 32'h0);
    check("clr_keys_valid", 32'(keys_valid), 32'h0);
    check("clr_key_ready", 32'(key_ready), 32'h1);
    rd(1'b0, 0, v, vv);
    check("clr_rd_v", 32'(vv), 32'h0);
    check("clr_rd_d", v, 32'h0);
    check("clr_still_idle", 32'(busy), 32'h0);

    // async reset pulse between edges mid-expansion
    key = STD_KEY; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_key_ready", 32'(key_ready), 32'h1);
    check("arst_keys_valid", 32'(keys_valid), 32'h0);
    check("arst_rk_valid", 32'(rk_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_and_wait(STD_KEY, 1'b0, cyc);
    check("reload_latency", 32'(cyc), 32'd33);
    rd(1'b0, 0, v, vv);
    check("reload_idx0", v, 32'hf12186f9);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d expected 0", n_fail);
    $fatal(1);
  end

endmodule
